// File: rtl/montgomery_mul_param.sv
// Parametrised Montgomery multiplier: result = in_a * in_b * 2^-WIDTH mod in_m.
// Consumes DIGIT multiplier bits per cycle; flags an even modulus with err.
module montgomery_mul_param #(
  parameter int WIDTH = 1024,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             err
);

  localparam int N        = WIDTH / DIGIT;
  localparam int CW       = WIDTH + 2;
  localparam int CNT_W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  if (((WIDTH % DIGIT) != 0) ||
      !((DIGIT == 1) || (DIGIT == 2) || (DIGIT == 4) || (DIGIT == 8))) begin : g_bad_param
    $error("montgomery_mul_param: DIGIT must be 1, 2, 4 or 8 and divide WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOOP  = 2'd1,
    S_FINAL = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;
  logic [WIDTH-1:0] m_p0;
  logic [CW-1:0]    c_p0;
  logic [CW-1:0]    c_step;
  logic [CNT_W-1:0] cnt_p0;

  // DIGIT interleaved radix-2 steps; C stays below 2M so WIDTH+2 bits never overflow.
  function automatic logic [CW-1:0] digit_step(input logic [CW-1:0]    c,
                                               input logic [DIGIT-1:0] a_dig,
                                               input logic [WIDTH-1:0] b,
                                               input logic [WIDTH-1:0] m);
    logic [CW-1:0] acc;
    acc = c;
    for (int j = 0; j < DIGIT; j++) begin
      if (a_dig[j]) acc = acc + {2'b00, b};
      if (acc[0])   acc = acc + {2'b00, m};
      acc = acc >> 1;
    end
    return acc;
  endfunction

  // Conditional final subtraction bringing C from [0, 2M) into [0, M).
  function automatic logic [WIDTH-1:0] final_reduce(input logic [CW-1:0]    c,
                                                    input logic [WIDTH-1:0] m);
    logic signed [CW-1:0] d;
    d = signed'(c) - signed'({2'b00, m});
    return d[CW-1] ? c[WIDTH-1:0] : d[WIDTH-1:0];
  endfunction

  assign c_step = digit_step(c_p0, a_p0[DIGIT-1:0], b_p0, m_p0);
  assign busy   = (state != S_IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = in_m[0] ? S_LOOP : S_ERR;
      S_LOOP:  if (cnt_p0 == CNT_LAST) state_nxt = S_FINAL;
      S_FINAL: state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, digit iteration and result/flag registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_p0   <= '0;
      b_p0   <= '0;
      m_p0   <= '0;
      c_p0   <= '0;
      cnt_p0 <= '0;
      result <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            a_p0   <= in_a;
            b_p0   <= in_b;
            m_p0   <= in_m;
            c_p0   <= '0;
            cnt_p0 <= '0;
            err    <= 1'b0;
          end
        end
        S_LOOP: begin
          c_p0   <= c_step;
          a_p0   <= a_p0 >> DIGIT;
          cnt_p0 <= cnt_p0 + CNT_W'(1);
        end
        S_FINAL: begin
          result <= final_reduce(c_p0, m_p0);
          done   <= 1'b1;
        end
        S_ERR: begin
          result <= '0;
          err    <= 1'b1;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
